// File: rtl/led_stream.sv
// led_stream -- serialises a stream of pixel words onto a single-wire LED strip
// using pulse-width coded bits, followed by a low latch gap after each frame.
//
// Each data bit occupies T_PERIOD clocks. The line is high for T_HIGH1 clocks
// for a 1 bit or T_HIGH0 clocks for a 0 bit, then low for the rest of the bit.
// A frame is LED_CNT pixels sent MSB first with no gap between pixels. After
// the frame the line stays low for T_LATCH clocks. A one-entry hold register
// lets the next pixel be prefetched while the current one is shifting out.
//
// Optional feature: define LED_STREAM_BRIGHTNESS_EN to add the brightness
// input. Each channel c is then scaled to (c*(brightness+1))>>8 as the pixel
// is loaded into the shift register.
//
// Ports:
//   clk         in   single clock, all logic on its rising edge
//   reset_n     in   synchronous active-low reset
//   brightness  in   [7:0] global scale (only with LED_STREAM_BRIGHTNESS_EN)
//   pix_data    in   [PIXW-1:0] pixel word, channel 0 in the MSBs
//   pix_valid   in   pix_data valid
//   pix_ready   out  block accepts a pixel this cycle
//   led_o       out  registered serial line to the strip
//   busy        out  high whenever the block is not idle
//   frame_done  out  one-cycle pulse on the last clock of the latch gap
//   underrun    out  one-cycle pulse when a frame is cut short for lack of data
//
// Timing note: led_o, busy, frame_done and underrun are all registered from
// the current state. They therefore trail the internal state by one clock and
// stay aligned with each other on the outputs.
module led_stream #(
    parameter int LED_CNT       = 3,
    parameter int CHANNELS      = 3,
    parameter int BITPERCHANNEL = 8,
    parameter int T_PERIOD      = 31,
    parameter int T_HIGH0       = 10,
    parameter int T_HIGH1       = 20,
    parameter int T_LATCH       = 1250
) (
    input  logic                                clk,
    input  logic                                reset_n,
`ifdef LED_STREAM_BRIGHTNESS_EN
    input  logic [7:0]                          brightness,
`endif
    input  logic [CHANNELS*BITPERCHANNEL-1:0]   pix_data,
    input  logic                                pix_valid,
    output logic                                pix_ready,
    output logic                                led_o,
    output logic                                busy,
    output logic                                frame_done,
    output logic                                underrun
);

    localparam int PIXW = CHANNELS * BITPERCHANNEL;
    localparam int TMAX = (T_PERIOD > T_LATCH) ? T_PERIOD : T_LATCH;
    localparam int CW   = $clog2(TMAX + 1);
    localparam int PCW  = $clog2(LED_CNT + 1);
    localparam int IW   = $clog2(PIXW + 1);

    localparam logic [CW-1:0]  PERIOD_LAST = CW'(T_PERIOD - 1);
    localparam logic [CW-1:0]  LATCH_LAST  = CW'(T_LATCH - 1);
    localparam logic [CW-1:0]  HIGH0_CNT   = CW'(T_HIGH0);
    localparam logic [CW-1:0]  HIGH1_CNT   = CW'(T_HIGH1);
    localparam logic [IW-1:0]  BIT_LAST    = IW'(PIXW - 1);
    localparam logic [PCW-1:0] PIX_LAST    = PCW'(LED_CNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BIT   = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

`ifdef LED_STREAM_BRIGHTNESS_EN
    localparam int PW = BITPERCHANNEL + 8;

    // Scales every channel by (brightness+1)/256; the product of a channel and
    // a 9-bit factor of at most 256 always fits in BITPERCHANNEL+8 bits.
    function automatic logic [PIXW-1:0] load_word(input logic [PIXW-1:0] px,
                                                  input logic [7:0]      br);
        logic [PIXW-1:0] res;
        logic [PW-1:0]   prod;
        res  = '0;
        prod = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            prod = PW'(px[c*BITPERCHANNEL +: BITPERCHANNEL]) * (PW'(br) + PW'(1));
            res[c*BITPERCHANNEL +: BITPERCHANNEL] = BITPERCHANNEL'(prod >> 8);
        end
        return res;
    endfunction
`else
    // Pixels go out exactly as received.
    function automatic logic [PIXW-1:0] load_word(input logic [PIXW-1:0] px);
        return px;
    endfunction
`endif

    state_t          state_q, state_d;
    logic [PIXW-1:0] hold_q, hold_d;
    logic            hold_full_q, hold_full_d;
    logic [PIXW-1:0] shift_q, shift_d;
    logic [CW-1:0]   tmr_q, tmr_d;        // bit timer in BIT, gap timer in LATCH
    logic [IW-1:0]   bit_idx_q, bit_idx_d;
    logic [PCW-1:0]  pix_cnt_q, pix_cnt_d;
    logic            led_q, led_d;
    logic            busy_q, busy_d;
    logic            frame_done_q, frame_done_d;
    logic            underrun_q, underrun_d;
    logic [PIXW-1:0] next_word;
    logic            pix_take;

    assign pix_ready  = ~hold_full_q & reset_n;
    assign pix_take   = pix_valid & pix_ready;
    assign led_o      = led_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

`ifdef LED_STREAM_BRIGHTNESS_EN
    assign next_word = load_word(hold_q, brightness);
`else
    assign next_word = load_word(hold_q);
`endif

    // Next-state, hold-register and output-pulse logic.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        shift_d      = shift_q;
        tmr_d        = tmr_q;
        bit_idx_d    = bit_idx_q;
        pix_cnt_d    = pix_cnt_q;
        led_d        = 1'b0;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        busy_d       = (state_q != ST_IDLE);

        // A pixel can only be taken while the hold register is empty, so this
        // never collides with the FSM draining the hold register below.
        if (pix_take) begin
            hold_d      = pix_data;
            hold_full_d = 1'b1;
        end else begin
            hold_d      = hold_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    shift_d     = next_word;
                    hold_full_d = 1'b0;
                    pix_cnt_d   = '0;
                    bit_idx_d   = '0;
                    tmr_d       = '0;
                    state_d     = ST_BIT;
                end else begin
                    state_d     = ST_IDLE;
                end
            end

            ST_BIT: begin
                if (shift_q[PIXW-1]) begin
                    led_d = (tmr_q < HIGH1_CNT);
                end else begin
                    led_d = (tmr_q < HIGH0_CNT);
                end

                if (tmr_q != PERIOD_LAST) begin
                    tmr_d = tmr_q + CW'(1);
                end else begin
                    tmr_d = '0;
                    if (bit_idx_q != BIT_LAST) begin
                        shift_d   = {shift_q[PIXW-2:0], 1'b0};
                        bit_idx_d = bit_idx_q + IW'(1);
                    end else if (pix_cnt_q == PIX_LAST) begin
                        state_d   = ST_LATCH;
                    end else if (hold_full_q) begin
                        // Back-to-back reload: the next pixel starts on the
                        // very next clock with no idle cycle.
                        shift_d     = next_word;
                        hold_full_d = 1'b0;
                        bit_idx_d   = '0;
                        pix_cnt_d   = pix_cnt_q + PCW'(1);
                    end else begin
                        // No data in time: abandon the frame and latch what
                        // the strip already has.
                        underrun_d = 1'b1;
                        state_d    = ST_LATCH;
                    end
                end
            end

            ST_LATCH: begin
                if (tmr_q == LATCH_LAST) begin
                    frame_done_d = 1'b1;
                    tmr_d        = '0;
                    state_d      = ST_IDLE;
                end else begin
                    tmr_d        = tmr_q + CW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            shift_q      <= '0;
            tmr_q        <= '0;
            bit_idx_q    <= '0;
            pix_cnt_q    <= '0;
            led_q        <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            shift_q      <= shift_d;
            tmr_q        <= tmr_d;
            bit_idx_q    <= bit_idx_d;
            pix_cnt_q    <= pix_cnt_d;
            led_q        <= led_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

endmodule

// File: tb/tb_led_stream.sv
// Directed self-checking bench for led_stream with default parameters.
// A passive monitor timestamps every led_o rise/fall, frame_done and underrun
// pulse in clock edges; the directed sequence then decodes the captured
// waveform and compares it with hand-written pixel values and timings.
module tb_led_stream;

    localparam int T_PERIOD = 31;
    localparam int T_HIGH0  = 10;
    localparam int T_HIGH1  = 20;
    localparam int T_LATCH  = 1250;

    logic        clk;
    logic        reset_n;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        led_o;
    logic        busy;
    logic        frame_done;
    logic        underrun;
`ifdef LED_STREAM_BRIGHTNESS_EN
    logic [7:0]  brightness;
`endif

    int errors = 0;
    int checks = 0;

    led_stream dut (
        .clk        (clk),
        .reset_n    (reset_n),
`ifdef LED_STREAM_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .led_o      (led_o),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges; at a negedge edge_cnt is the number of the last posedge.
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Waveform capture.
    int   rise_q[$];
    int   width_q[$];
    int   fd_q[$];
    int   ur_q[$];
    logic led_prev = 1'b0;
    int   rise_at  = 0;
    always @(negedge clk) begin
        if (led_o === 1'b1 && led_prev === 1'b0) begin
            rise_q.push_back(edge_cnt);
            rise_at <= edge_cnt;
        end
        if (led_o === 1'b0 && led_prev === 1'b1) width_q.push_back(edge_cnt - rise_at);
        if (frame_done === 1'b1) fd_q.push_back(edge_cnt);
        if (underrun === 1'b1) ur_q.push_back(edge_cnt);
        led_prev <= (led_o === 1'b1);
    end

    logic [23:0] exp_pix [0:19];
    int rb, fb, ub, a0, acc0, sidx;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [23:0] px, output int acc_edge);
        acc_edge  = -1;
        pix_data  = px;
        pix_valid = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            if (pix_ready === 1'b1) begin
                acc_edge = edge_cnt + 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        chk("send_accepted", {31'd0, acc_edge >= 0}, 32'd1);
    endtask

    task automatic wait_fd(input int target);
        for (int c = 0; c < 6000 && fd_q.size() < target; c++) @(negedge clk);
        chk("frame_done_seen", {31'd0, fd_q.size() >= target}, 32'd1);
    endtask

    // Decode npix pixels starting at rise index r0 and compare against
    // exp_pix[first..]; also checks bit spacing and the gap to frame_done fdi.
    task automatic verify_frame(input int r0, input int npix, input int first,
                                input int fdi, input string tag);
        int nb;
        int bad_p;
        int bad_w;
        int wd;
        logic [23:0] w;
        nb    = npix * 24;
        bad_p = 0;
        bad_w = 0;
        chk({tag, "_bits_captured"},
            {31'd0, (rise_q.size() >= r0 + nb) && (width_q.size() >= r0 + nb) && (fd_q.size() > fdi)},
            32'd1);
        if ((rise_q.size() >= r0 + nb) && (width_q.size() >= r0 + nb) && (fd_q.size() > fdi)) begin
            for (int i = 0; i < nb - 1; i++) begin
                if (rise_q[r0+i+1] - rise_q[r0+i] != T_PERIOD) bad_p++;
            end
            chk({tag, "_bit_period"}, bad_p, 32'd0);
            for (int p = 0; p < npix; p++) begin
                w = 24'd0;
                for (int b = 0; b < 24; b++) begin
                    wd = width_q[r0 + p*24 + b];
                    w  = {w[22:0], (wd == T_HIGH1)};
                    if (wd != T_HIGH1 && wd != T_HIGH0) bad_w++;
                end
                chk({tag, "_pixel"}, {8'd0, w}, {8'd0, exp_pix[first+p]});
            end
            chk({tag, "_high_width"}, bad_w, 32'd0);
            chk({tag, "_latch_gap"}, fd_q[fdi] - rise_q[r0+nb-1], T_PERIOD + T_LATCH - 1);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 24'd0;
`ifdef LED_STREAM_BRIGHTNESS_EN
        brightness = 8'd255;
`endif
        exp_pix[0]  = 24'hFF0000; exp_pix[1]  = 24'h00FF00; exp_pix[2]  = 24'h0000FF;
        exp_pix[3]  = 24'h800001; exp_pix[4]  = 24'h123456; exp_pix[5]  = 24'hA5C33C;
        exp_pix[6]  = 24'h5AA55A; exp_pix[7]  = 24'h0F0F0F; exp_pix[8]  = 24'hF0F0F0;
        exp_pix[9]  = 24'hC3C3C3; exp_pix[10] = 24'h3C3C3C;
        exp_pix[11] = 24'h0A0B0C; exp_pix[12] = 24'hFEDCBA; exp_pix[13] = 24'h010203;
        exp_pix[14] = 24'h7F4001; exp_pix[15] = 24'h7F7F7F; exp_pix[16] = 24'h091A2B;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_led_o", {31'd0, led_o}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
        chk("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_pix_ready", {31'd0, pix_ready}, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Frame A: three primaries back to back.
        rb = rise_q.size(); fb = fd_q.size(); ub = ur_q.size();
        send(exp_pix[0], a0);
        send(exp_pix[1], acc0);
        send(exp_pix[2], acc0);
        chk("A_busy_during_frame", {31'd0, busy}, 32'd1);
        chk("A_first_rise", rise_q[rb] - a0, 32'd2);
        wait_fd(fb + 1);
        verify_frame(rb, 3, 0, fb, "A");
        repeat (20) @(negedge clk);
        chk("A_rise_total", rise_q.size() - rb, 32'd72);
        chk("A_one_frame_done", fd_q.size() - fb, 32'd1);
        chk("A_no_underrun", ur_q.size() - ub, 32'd0);
        chk("A_busy_after", {31'd0, busy}, 32'd0);

        // Frame B: pix_valid held high across two full frames.
        rb = rise_q.size(); fb = fd_q.size(); ub = ur_q.size();
        pix_valid = 1'b1;
        sidx      = 0;
        acc0      = -1;
        pix_data  = exp_pix[3];
        for (int c = 0; c < 20000 && sidx < 6; c++) begin
            if (pix_ready === 1'b1) begin
                if (sidx == 0) acc0 = edge_cnt + 1;
                @(negedge clk);
                chk("B_ready_low_when_full", {31'd0, pix_ready}, 32'd0);
                sidx++;
                if (sidx < 6) pix_data = exp_pix[3+sidx];
            end else begin
                @(negedge clk);
            end
        end
        pix_valid = 1'b0;
        chk("B_all_accepted", sidx, 32'd6);
        wait_fd(fb + 1);
        wait_fd(fb + 2);
        chk("B_first_rise", rise_q[rb] - acc0, 32'd2);
        chk("B_first_high", width_q[rb], T_HIGH1);
        chk("B_first_period", rise_q[rb+1] - rise_q[rb], T_PERIOD);
        verify_frame(rb, 3, 3, fb, "B1");
        verify_frame(rb + 72, 3, 6, fb + 1, "B2");
        repeat (20) @(negedge clk);
        chk("B_rise_total", rise_q.size() - rb, 32'd144);
        chk("B_no_underrun", ur_q.size() - ub, 32'd0);

        // Frame C: only two pixels -> underrun after bit 48.
        rb = rise_q.size(); fb = fd_q.size(); ub = ur_q.size();
        send(exp_pix[9], a0);
        send(exp_pix[10], a0);
        wait_fd(fb + 1);
        chk("C_underrun_count", ur_q.size() - ub, 32'd1);
        if (ur_q.size() > ub && rise_q.size() >= rb + 48 && fd_q.size() > fb) begin
            chk("C_underrun_edge", ur_q[ub] - rise_q[rb+47], T_PERIOD - 1);
            chk("C_latch_after_underrun", fd_q[fb] - ur_q[ub], T_LATCH);
        end
        verify_frame(rb, 2, 9, fb, "C");
        repeat (20) @(negedge clk);
        chk("C_rise_total", rise_q.size() - rb, 32'd48);
        chk("C_one_frame_done", fd_q.size() - fb, 32'd1);

        // Reset at the 10th bit of a frame.
        rb = rise_q.size(); fb = fd_q.size(); ub = ur_q.size();
        send(24'hC0FFEE, a0);
        send(24'h123456, a0);
        for (int c = 0; c < 2000 && rise_q.size() < rb + 10; c++) @(negedge clk);
        chk("D_reached_bit10", {31'd0, rise_q.size() >= rb + 10}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("D_led_low", {31'd0, led_o}, 32'd0);
        chk("D_busy_low", {31'd0, busy}, 32'd0);
        chk("D_ready_low", {31'd0, pix_ready}, 32'd0);
        reset_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("D_no_more_bits", rise_q.size() - rb, 32'd10);
        chk("D_no_frame_done", fd_q.size() - fb, 32'd0);
        chk("D_no_underrun", ur_q.size() - ub, 32'd0);
        chk("D_idle_after", {31'd0, busy}, 32'd0);

        // Frame E: clean frame after the reset.
        rb = rise_q.size(); fb = fd_q.size();
        send(exp_pix[11], a0);
        send(exp_pix[12], acc0);
        send(exp_pix[13], acc0);
        chk("E_first_rise", rise_q[rb] - a0, 32'd2);
        wait_fd(fb + 1);
        verify_frame(rb, 3, 11, fb, "E");

`ifdef LED_STREAM_BRIGHTNESS_EN
        // Frame F: brightness 127 halves every channel.
        repeat (5) @(negedge clk);
        brightness = 8'd127;
        rb = rise_q.size(); fb = fd_q.size();
        send(24'hFF8002, a0);
        send(24'hFFFFFF, a0);
        send(24'h123456, a0);
        wait_fd(fb + 1);
        verify_frame(rb, 3, 14, fb, "F");
`endif

        repeat (10) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
